// File: rtl/mcu_pkg.sv
// Shared types and opcode match constants for the multicycle LEGv8 control unit.
// ITYPE_ALU_EN adds the ADDI/SUBI match constants and their path selects.
package mcu_pkg;

   localparam int OPC_BITS = 11;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd7
   } mcu_state_e;

   typedef enum logic [2:0] {
      CLS_NONE    = 3'd0,
      CLS_RTYPE   = 3'd1,
      CLS_LDUR    = 3'd2,
      CLS_STUR    = 3'd3,
      CLS_CBZ     = 3'd4,
      CLS_ITYPE   = 3'd5,
      CLS_ILLEGAL = 3'd6
   } mcu_class_e;

   typedef struct packed {
      logic       reg2loc;
      logic       alu_src;
      logic       mem_to_reg;
      logic [1:0] alu_op;
   } path_sel_t;

   // Each opcode pattern is a value/mask pair; mask bits of 0 are don't-cares.
   localparam logic [OPC_BITS-1:0] RTYPE_VAL  = 11'b10001010000;
   localparam logic [OPC_BITS-1:0] RTYPE_MASK = 11'b10011110111;
   localparam logic [OPC_BITS-1:0] LDUR_VAL   = 11'b11111000010;
   localparam logic [OPC_BITS-1:0] LDUR_MASK  = 11'b11111111111;
   localparam logic [OPC_BITS-1:0] STUR_VAL   = 11'b11111000000;
   localparam logic [OPC_BITS-1:0] STUR_MASK  = 11'b11111111111;
   localparam logic [OPC_BITS-1:0] CBZ_VAL    = 11'b10110100000;
   localparam logic [OPC_BITS-1:0] CBZ_MASK   = 11'b11111111000;

   localparam path_sel_t PATH_NONE  = '{reg2loc: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0, alu_op: 2'b00};
   localparam path_sel_t PATH_RTYPE = '{reg2loc: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0, alu_op: 2'b10};
   localparam path_sel_t PATH_LDUR  = '{reg2loc: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b1, alu_op: 2'b00};
   localparam path_sel_t PATH_STUR  = '{reg2loc: 1'b1, alu_src: 1'b1, mem_to_reg: 1'b0, alu_op: 2'b00};
   localparam path_sel_t PATH_CBZ   = '{reg2loc: 1'b1, alu_src: 1'b0, mem_to_reg: 1'b0, alu_op: 2'b01};

`ifdef ITYPE_ALU_EN
   localparam logic [OPC_BITS-1:0] ADDI_VAL   = 11'b10010001000;
   localparam logic [OPC_BITS-1:0] SUBI_VAL   = 11'b11010001000;
   localparam logic [OPC_BITS-1:0] ITYPE_MASK = 11'b11111111110;
   localparam path_sel_t PATH_ITYPE = '{reg2loc: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0, alu_op: 2'b10};
`endif

   function automatic logic opc_match(input logic [OPC_BITS-1:0] opc,
                                      input logic [OPC_BITS-1:0] val,
                                      input logic [OPC_BITS-1:0] mask);
      return (opc & mask) == val;
   endfunction

endpackage

// File: rtl/mcu_opcode_decoder.sv
// Combinational opcode-to-class and path-select lookup for the multicycle control unit.
// Macro ITYPE_ALU_EN additionally accepts ADDI/SUBI as the ITYPE class.
module mcu_opcode_decoder
   import mcu_pkg::*;
(
   input  logic [OPC_BITS-1:0] opcode,
   output logic [2:0]          cls,
   output logic [4:0]          path
);

   mcu_class_e cls_int;
   path_sel_t  path_int;

   // First match wins, so exact memory opcodes shadow the wider R-type pattern.
   always_comb begin
      cls_int  = CLS_ILLEGAL;
      path_int = PATH_NONE;
      if (opc_match(opcode, LDUR_VAL, LDUR_MASK)) begin
         cls_int  = CLS_LDUR;
         path_int = PATH_LDUR;
      end else if (opc_match(opcode, STUR_VAL, STUR_MASK)) begin
         cls_int  = CLS_STUR;
         path_int = PATH_STUR;
      end else if (opc_match(opcode, CBZ_VAL, CBZ_MASK)) begin
         cls_int  = CLS_CBZ;
         path_int = PATH_CBZ;
      end else if (opc_match(opcode, RTYPE_VAL, RTYPE_MASK)) begin
         cls_int  = CLS_RTYPE;
         path_int = PATH_RTYPE;
      end
`ifdef ITYPE_ALU_EN
      else if (opc_match(opcode, ADDI_VAL, ITYPE_MASK) ||
               opc_match(opcode, SUBI_VAL, ITYPE_MASK)) begin
         cls_int  = CLS_ITYPE;
         path_int = PATH_ITYPE;
      end
`endif
   end

   assign cls  = cls_int;
   assign path = path_int;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle LEGv8 control FSM with memory handshake, dmem timeout, illegal trap and retire counter.
// Macro ITYPE_ALU_EN (in the decoder) enables the ADDI/SUBI class.
module multicycle_control_unit
   import mcu_pkg::*;
#(
   parameter int OPCODE_W    = 11,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] instr_opcode,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic                Reg2Loc,
   output logic                ALUSrc,
   output logic                MemtoReg,
   output logic [1:0]          ALUOp,
   output logic                RegWrite,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                Branch,
   output logic                IRWrite,
   output logic                PCWrite,
   output logic                illegal,
   output logic                bus_err,
   output logic [2:0]          state,
   output logic [CNT_W-1:0]    retired
);

   localparam int                WAIT_W    = 8;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   logic [2:0]        state_q;
   logic [2:0]        state_d;
   mcu_class_e        cls_q;
   path_sel_t         path_q;
   logic [WAIT_W-1:0] wait_q;
   logic              illegal_q;
   logic              bus_err_q;
   logic [CNT_W-1:0]  retired_q;

   logic [2:0]        dec_cls_raw;
   logic [4:0]        dec_path_raw;
   mcu_class_e        dec_cls;
   path_sel_t         dec_path;
   logic              in_mem;
   logic              mem_timeout;
   logic              pc_write;

   generate
      if (OPCODE_W > OPC_BITS) begin : g_low_bits
         logic unused_low_bits;
         assign unused_low_bits = ^instr_opcode[OPCODE_W-OPC_BITS-1:0];
      end
   endgenerate

   mcu_opcode_decoder u_decoder (
      .opcode (instr_opcode[OPCODE_W-1 -: OPC_BITS]),
      .cls    (dec_cls_raw),
      .path   (dec_path_raw)
   );

   assign dec_cls  = mcu_class_e'(dec_cls_raw);
   assign dec_path = dec_path_raw;

   // The wait counter holds the number of stalled MEM cycles already spent, so the
   // stall that would bring it to MEM_TIMEOUT is the one that traps; ready still wins.
   assign in_mem      = (state_q == ST_MEM);
   assign mem_timeout = in_mem && !dmem_ready && (wait_q == WAIT_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:  if (imem_ready) state_d = ST_DECODE;
         ST_DECODE: state_d = (dec_cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
         ST_EXEC: begin
            case (cls_q)
               CLS_RTYPE, CLS_ITYPE: state_d = ST_WB;
               CLS_LDUR, CLS_STUR:   state_d = ST_MEM;
               CLS_CBZ:              state_d = ST_FETCH;
               default:              state_d = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            if (dmem_ready) begin
               if (cls_q == CLS_LDUR)      state_d = ST_WB;
               else if (cls_q == CLS_STUR) state_d = ST_FETCH;
               else                        state_d = ST_TRAP;
            end else if (mem_timeout) begin
               state_d = ST_TRAP;
            end
         end
         ST_WB:     state_d = ST_FETCH;
         ST_TRAP:   state_d = ST_TRAP;
         default:   state_d = ST_FETCH;
      endcase
   end

   // Class and path selects are captured once in DECODE and dropped as the instruction ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         cls_q   <= CLS_NONE;
         path_q  <= PATH_NONE;
      end else begin
         state_q <= state_d;
         if (state_q == ST_DECODE) begin
            cls_q  <= dec_cls;
            path_q <= dec_path;
         end else if (state_d == ST_FETCH || state_d == ST_TRAP) begin
            cls_q  <= CLS_NONE;
            path_q <= PATH_NONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         wait_q <= (in_mem && !dmem_ready) ? wait_q + 1'b1 : '0;
         if (state_q == ST_DECODE && dec_cls == CLS_ILLEGAL) illegal_q <= 1'b1;
         if (mem_timeout) bus_err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= '0;
      end else if (pc_write) begin
         retired_q <= retired_q + 1'b1;
      end
   end

   // A store retires in the MEM cycle its handshake completes, so PCWrite sees dmem_ready there.
   assign pc_write = (state_q == ST_WB) ||
                     (state_q == ST_EXEC && cls_q == CLS_CBZ) ||
                     (in_mem && cls_q == CLS_STUR && dmem_ready);

   assign IRWrite  = rst_n && (state_q == ST_FETCH) && imem_ready;
   assign PCWrite  = pc_write;
   assign RegWrite = (state_q == ST_WB);
   assign MemRead  = in_mem && (cls_q == CLS_LDUR);
   assign MemWrite = in_mem && (cls_q == CLS_STUR);
   assign Branch   = (state_q == ST_EXEC) && (cls_q == CLS_CBZ);

   assign Reg2Loc  = path_q.reg2loc;
   assign ALUSrc   = path_q.alu_src;
   assign MemtoReg = path_q.mem_to_reg;
   assign ALUOp    = path_q.alu_op;

   assign illegal  = illegal_q;
   assign bus_err  = bus_err_q;
   assign state    = state_q;
   assign retired  = retired_q;

endmodule
